// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch unit: FSM state,
// reset/bubble words and the memory index width helper.
package fetch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

  // Number of word-index bits needed to address a memory of mem_words words.
  function automatic int addr_bits(input int mem_words);
    return $clog2(mem_words);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory bus: the fetch unit drives a word index and the
// combinational memory returns the word stored there in the same cycle.
interface instruction_fetch_unit_if;

  logic [31:0] instructionAddress;
  logic [31:0] instructionIn;

  modport master (
    output instructionAddress,
    input  instructionIn
  );

  modport slave (
    input  instructionAddress,
    output instructionIn
  );

endinterface

// File: rtl/instruction_fetch_unit_if_id_register.sv
// IF/ID pipeline register: instruction, its byte PC, PC+4 and a valid flag,
// with flush > hold > load priority.
module if_id_register #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        hold,
  input  logic        flush,
  input  logic [31:0] instruction_d,
  input  logic [31:0] pc_d,
  input  logic [31:0] pc_plus4_d,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  // NOTE: sequential state is written only with <= so every register samples
  // its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction <= NOP_WORD;
      pc          <= 32'h0000_0000;
      pc_plus4    <= 32'h0000_0004;
      valid       <= 1'b0;
    end else if (flush) begin
      instruction <= NOP_WORD;
      pc          <= 32'h0000_0000;
      pc_plus4    <= 32'h0000_0004;
      valid       <= 1'b0;
    end else if (!hold && load) begin
      instruction <= instruction_d;
      pc          <= pc_d;
      pc_plus4    <= pc_plus4_d;
      valid       <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: program counter, IDLE/RUN sequencing and the
// next-PC mux, feeding the IF/ID register from a combinational memory.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_WORD  = DEFAULT_NOP_WORD
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            start,
  input  logic                            stall,
  input  logic                            redirect,
  input  logic [31:0]                     redirectTarget,
  instruction_fetch_unit_if.master        mem,
  output logic [31:0]                     instructionOut,
  output logic [31:0]                     programCounterOut,
  output logic [31:0]                     pcPlus4Out,
  output logic                            validOut,
  output logic                            misalignedTarget
);

  localparam int ADDR_BITS = addr_bits(MEM_WORDS);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        running;

  assign running  = (state == RUN);
  assign pc_plus4 = pc + 32'd4;

  // Only the index bits reach memory, so fetch wraps every MEM_WORDS words
  // while the full PC keeps counting modulo 2^32.
  assign mem.instructionAddress = {{(32 - ADDR_BITS){1'b0}}, pc[ADDR_BITS+1:2]};

  assign misalignedTarget = running && redirect && (redirectTarget[1:0] != 2'b00);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          pc <= RESET_PC;
          if (start) state <= RUN;
        end
        RUN: begin
          if (redirect)    pc <= {redirectTarget[31:2], 2'b00};
          else if (!stall) pc <= pc_plus4;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Redirect outranks stall, so a flush is never blocked by a held pipeline.
  if_id_register #(
    .NOP_WORD (NOP_WORD)
  ) u_if_id (
    .clk           (Clk),
    .rst           (Reset),
    .load          (running),
    .hold          (stall),
    .flush         (!running || redirect),
    .instruction_d (mem.instructionIn),
    .pc_d          (pc),
    .pc_plus4_d    (pc_plus4),
    .instruction   (instructionOut),
    .pc            (programCounterOut),
    .pc_plus4      (pcPlus4Out),
    .valid         (validOut)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a 1024-word combinational memory
// holding 32'hC0DE_0000 | index, with hand-computed expectations per step.
module tb_instruction_fetch_unit;

  logic        Clk;
  logic        Reset;
  logic        start;
  logic        stall;
  logic        redirect;
  logic [31:0] redirectTarget;
  logic [31:0] instructionOut;
  logic [31:0] programCounterOut;
  logic [31:0] pcPlus4Out;
  logic        validOut;
  logic        misalignedTarget;

  int errors = 0;
  int checks = 0;

  logic [31:0] memory [1024];

  instruction_fetch_unit_if mem_if ();

  assign mem_if.instructionIn = memory[mem_if.instructionAddress[9:0]];

  instruction_fetch_unit #(
    .MEM_WORDS (1024),
    .RESET_PC  (32'h0000_0000),
    .NOP_WORD  (32'h0000_0000)
  ) dut (
    .Clk               (Clk),
    .Reset             (Reset),
    .start             (start),
    .stall             (stall),
    .redirect          (redirect),
    .redirectTarget    (redirectTarget),
    .mem               (mem_if.master),
    .instructionOut    (instructionOut),
    .programCounterOut (programCounterOut),
    .pcPlus4Out        (pcPlus4Out),
    .validOut          (validOut),
    .misalignedTarget  (misalignedTarget)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] instr,
                            input logic [31:0] pc, input logic valid);
    check({tag, "_instr"}, instructionOut, instr);
    check({tag, "_pc"}, programCounterOut, pc);
    check({tag, "_pc4"}, pcPlus4Out, pc + 32'd4);
    check({tag, "_valid"}, {31'b0, validOut}, {31'b0, valid});
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) memory[i] = 32'hC0DE_0000 | 32'(i);

    Reset = 1'b1; start = 1'b0; stall = 1'b0; redirect = 1'b0; redirectTarget = 32'h0;
    #2;
    check_ifid("reset", 32'h0, 32'h0, 1'b0);
    check("reset_addr", mem_if.instructionAddress, 32'h0);
    check("reset_mis", {31'b0, misalignedTarget}, 32'h0);
    #10 Reset = 1'b0;

    // IDLE ignores redirect/stall; misalignment is not reported outside RUN.
    redirect = 1'b1; redirectTarget = 32'h0000_0082; stall = 1'b1;
    #1;
    check("idle_mis", {31'b0, misalignedTarget}, 32'h0);
    step();
    step();
    check_ifid("idle", 32'h0, 32'h0, 1'b0);
    check("idle_addr", mem_if.instructionAddress, 32'h0);
    redirect = 1'b0; stall = 1'b0;

    // Start: one edge to enter RUN, then A0, A1 on consecutive edges.
    start = 1'b1;
    step();
    check("start_valid", {31'b0, validOut}, 32'h0);
    start = 1'b0;
    step();
    check_ifid("a0", 32'hC0DE_0000, 32'h0, 1'b1);
    check("a0_addr", mem_if.instructionAddress, 32'd1);
    step();
    check_ifid("a1", 32'hC0DE_0001, 32'h4, 1'b1);
    check("a1_addr", mem_if.instructionAddress, 32'd2);

    // Three stalled cycles at PC=8 hold everything.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_ifid("stall", 32'hC0DE_0001, 32'h4, 1'b1);
      check("stall_addr", mem_if.instructionAddress, 32'd2);
    end
    stall = 1'b0;
    step();
    check_ifid("a2", 32'hC0DE_0002, 32'h8, 1'b1);
    check("a2_addr", mem_if.instructionAddress, 32'd3);

    // Redirect to 0x40 together with stall at PC=12: redirect wins.
    redirect = 1'b1; stall = 1'b1; redirectTarget = 32'h0000_0040;
    #1;
    check("redir_mis", {31'b0, misalignedTarget}, 32'h0);
    step();
    check_ifid("bubble", 32'h0, 32'h0, 1'b0);
    check("bubble_addr", mem_if.instructionAddress, 32'h10);
    redirect = 1'b0; stall = 1'b0;
    step();
    check_ifid("tgt40", 32'hC0DE_0010, 32'h40, 1'b1);

    // Misaligned redirect to 0x42 is reported and fetch proceeds from 0x40.
    redirect = 1'b1; redirectTarget = 32'h0000_0042;
    #1;
    check("mis_high", {31'b0, misalignedTarget}, 32'h1);
    step();
    check_ifid("mis_bubble", 32'h0, 32'h0, 1'b0);
    check("mis_addr", mem_if.instructionAddress, 32'h10);
    redirect = 1'b0;
    #1;
    check("mis_low", {31'b0, misalignedTarget}, 32'h0);
    step();
    check_ifid("mis_tgt", 32'hC0DE_0010, 32'h40, 1'b1);

    // Wrap: 0xFFC is the last word; the next fetch is index 0 at PC 0x1000.
    redirect = 1'b1; redirectTarget = 32'h0000_0FFC;
    step();
    check("wrap_addr_last", mem_if.instructionAddress, 32'h3FF);
    redirect = 1'b0;
    step();
    check_ifid("wrap_last", 32'hC0DE_03FF, 32'hFFC, 1'b1);
    check("wrap_addr_zero", mem_if.instructionAddress, 32'h0);
    step();
    check_ifid("wrap_first", 32'hC0DE_0000, 32'h1000, 1'b1);

    // Asynchronous reset between edges takes effect immediately.
    redirect = 1'b1; redirectTarget = 32'h0000_0043;
    #2 Reset = 1'b1;
    #1;
    check_ifid("async_rst", 32'h0, 32'h0, 1'b0);
    check("async_rst_addr", mem_if.instructionAddress, 32'h0);
    check("async_rst_mis", {31'b0, misalignedTarget}, 32'h0);
    Reset = 1'b0; redirect = 1'b0;

    step();
    step();
    check_ifid("post_rst_idle", 32'h0, 32'h0, 1'b0);
    check("post_rst_addr", mem_if.instructionAddress, 32'h0);

    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check_ifid("restart_a0", 32'hC0DE_0000, 32'h0, 1'b1);
    step();
    check_ifid("restart_a1", 32'hC0DE_0001, 32'h4, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Initiator side of the instruction-memory interface. Owns the program counter, presents a word address to the combinational instruction memory each cycle, and captures the returned word into the IF/ID pipeline register. Sits between the hazard/branch logic, which drives stall and redirect, and the decode stage, which consumes instructionOut, programCounterOut, pcPlus4Out and validOut.

## Interface
- MEM_WORDS, 1024: instruction memory depth in words. Power of two.
- RESET_PC, 32'h0000_0000: byte PC loaded on reset. Word-aligned.
- NOP_WORD, 32'h0000_0000: word inserted into IF/ID on flush or idle.
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- start  in  1  level; leaves IDLE when sampled high
- stall  in  1  hold PC and IF/ID contents
- redirect  in  1  branch/jump taken; load redirectTarget, flush IF/ID
- redirectTarget  in  32  byte address of next fetch
- instructionIn  in  32  word returned by instruction memory for instructionAddress
- instructionAddress  out  32  word index to memory = zero-extended PC[log2(MEM_WORDS)+1:2]
- instructionOut  out  32  IF/ID instruction
- programCounterOut  out  32  byte PC of instructionOut
- pcPlus4Out  out  32  programCounterOut + 4
- validOut  out  1  IF/ID holds a real instruction
- misalignedTarget  out  1  one-cycle pulse: redirectTarget[1:0] != 0 on an accepted redirect

## Operation
- The FSM has two states, IDLE and RUN. Reset enters IDLE.
- IDLE:
  - PC holds RESET_PC.
  - IF/ID holds NOP_WORD with validOut=0.
  - stall and redirect are ignored.
  - start=1 moves to RUN on the next edge.
- RUN: each edge, in priority order:
  1. redirect=1: PC ← {redirectTarget[31:2],2'b00}. IF/ID ← NOP_WORD with validOut=0, programCounterOut=0 and pcPlus4Out=4. Redirect wins over stall. misalignedTarget=1 for that cycle if redirectTarget[1:0]!=0.
  2. stall=1: PC and all IF/ID fields hold.
  3. Otherwise: IF/ID ← {instructionIn, PC, PC+4} with validOut=1, and PC ← PC+4.
- Wrap-around:
  - PC is a full 32-bit register that wraps modulo 2^32.
  - instructionAddress uses only the index bits, so fetch wraps modulo MEM_WORDS words.
  - PC=4*MEM_WORDS−4 is followed by address 0.
- RUN is left only by Reset. start is don't-care in RUN.
- Reset mid-operation forces, asynchronously and without waiting for Clk:
  - the IDLE state and PC=RESET_PC;
  - instructionOut=NOP_WORD, validOut=0, programCounterOut=0, pcPlus4Out=4;
  - misalignedTarget=0.

## Timing
- Reset values of outputs: instructionAddress=RESET_PC[..:2], instructionOut=NOP_WORD, programCounterOut=0, pcPlus4Out=4, validOut=0, misalignedTarget=0.
- instructionAddress is combinational from the PC register only. No input-to-output combinational path.
- The instruction fetched from PC=p appears on instructionOut one edge after PC=p is presented (latency 1).
- Redirect penalty is one bubble cycle. The target instruction appears on the edge after the bubble.
- misalignedTarget is combinational from redirect & redirectTarget[1:0] and is asserted only in RUN.
- Steady-state throughput is one instruction per cycle with no stall.

## Structure
- Shared package `fetch_pkg`:
  - state enum {IDLE, RUN};
  - NOP_WORD and RESET_PC defaults;
  - the ADDR_BITS = $clog2(MEM_WORDS) helper.
- One sub-module, `if_id_register`, holds instruction, PC, PC+4 and valid. It has load, hold and flush controls and an async reset.
- The PC register, next-PC mux and FSM live in the top module.

## Test plan
- Reset, then start=1 with memory[0..3]=A0,A1,A2,A3 → instructionOut reads A0,A1,A2,A3 on consecutive edges with validOut=1 and programCounterOut=0,4,8,12.
- Stall held for 3 cycles while PC=8 → instructionAddress stays 2, IF/ID holds A1/PC 4, and the sequence resumes with A2.
- Redirect to 0x40 asserted together with stall while PC=12 → next edge validOut=0 with NOP_WORD, then instructionOut=memory[16] with programCounterOut=0x40.
- Redirect to 0x42 → misalignedTarget=1 for one cycle and fetch proceeds from 0x40.
- Redirect to 0xFFC with MEM_WORDS=1024, no stalls → the fetch after 0xFFC presents instructionAddress=0 and programCounterOut=0x1000.
- Reset asserted mid-cycle in RUN → outputs take their reset values immediately. Fetch stays idle with start=0, and after start=1 it restarts at address 0.
